// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-side constants: reset PC and the sequential PC increment,
// kept in step with the fetch unit.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_ctrl_pending_redirect.sv
// Holds a branch/jump redirect that arrived while fetch was stalled and
// selects the next PC (fresh redirect > pending redirect > PC + 4).
module pending_redirect
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o
);

  logic        pend_flag_q;
  logic        pend_flag_d;
  logic [31:0] pend_tgt_q;
  logic [31:0] pend_tgt_d;

  // Next-PC select: a fresh pulse wins over anything parked during a stall.
  always_comb begin
    npc_o = pc_i + PC_INCR;
    if (br_valid_i) begin
      npc_o = br_target_i;
    end else if (pend_flag_q) begin
      npc_o = pend_tgt_q;
    end else begin
      npc_o = pc_i + PC_INCR;
    end
  end

  always_comb begin
    pend_flag_d = pend_flag_q;
    pend_tgt_d  = pend_tgt_q;
    if (stall_i) begin
      if (br_valid_i) begin
        pend_flag_d = 1'b1;
        pend_tgt_d  = br_target_i;
      end else begin
        pend_flag_d = pend_flag_q;
        pend_tgt_d  = pend_tgt_q;
      end
    end else begin
      // Any selected redirect is handed to the fetch unit this cycle.
      pend_flag_d = 1'b0;
      pend_tgt_d  = pend_tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_flag_q <= 1'b0;
      pend_tgt_q  <= 32'd0;
    end else begin
      pend_flag_q <= pend_flag_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-side controller: next-PC/PC-enable generation, IF/ID pipeline
// register (delay slot never squashed) and debug fetch/stall counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FC_i_PC,
  input  logic [31:0] FC_i_Instr,
  input  logic        FC_i_Stall,
  input  logic        FC_i_BrValid,
  input  logic [31:0] FC_i_BrTarget,
  output logic [31:0] FC_o_nPC,
  output logic        FC_o_En,
  output logic [31:0] FC_o_D_Instr,
  output logic [31:0] FC_o_D_PC,
  output logic        FC_o_D_Valid,
  output logic [31:0] FC_o_FetchCnt,
  output logic [31:0] FC_o_StallCnt
);

  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  pending_redirect u_pending_redirect (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (FC_i_Stall),
    .br_valid_i  (FC_i_BrValid),
    .br_target_i (FC_i_BrTarget),
    .pc_i        (FC_i_PC),
    .npc_o       (FC_o_nPC)
  );

  assign FC_o_En = ~FC_i_Stall;

  always_comb begin
    d_instr_d   = d_instr_q;
    d_pc_d      = d_pc_q;
    d_valid_d   = d_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (FC_i_Stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      d_instr_d   = FC_i_Instr;
      d_pc_d      = FC_i_PC;
      d_valid_d   = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_instr_q   <= 32'd0;
      d_pc_q      <= RESET_PC;
      d_valid_q   <= 1'b0;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      d_instr_q   <= d_instr_d;
      d_pc_q      <= d_pc_d;
      d_valid_q   <= d_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FC_o_D_Instr  = d_instr_q;
  assign FC_o_D_PC     = d_pc_q;
  assign FC_o_D_Valid  = d_valid_q;
  assign FC_o_FetchCnt = fetch_cnt_q;
  assign FC_o_StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each scenario task drives inputs and
// compares outputs against hand-computed values.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] npc;
  logic        en;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .reset         (reset),
    .FC_i_PC       (pc),
    .FC_i_Instr    (instr),
    .FC_i_Stall    (stall),
    .FC_i_BrValid  (br_valid),
    .FC_i_BrTarget (br_target),
    .FC_o_nPC      (npc),
    .FC_o_En       (en),
    .FC_o_D_Instr  (d_instr),
    .FC_o_D_PC     (d_pc),
    .FC_o_D_Valid  (d_valid),
    .FC_o_FetchCnt (fetch_cnt),
    .FC_o_StallCnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0;
    pc = 32'h0000_3000; instr = 32'hDEAD_BEEF; br_target = 32'h0;
    step(); step();
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=%h", d_valid, 1'b0); end
    total++; if (d_pc !== 32'h0000_3000) begin bad++; $display("FAIL rst_pc got=%h exp=%h", d_pc, 32'h0000_3000); end
    total++; if (d_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=%h", d_instr, 32'h0); end
    total++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", fetch_cnt, stall_cnt); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL rst_en got=%b exp=1", en); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    stall = 1'b0; pc = 32'h0000_3000; instr = 32'h2401_0001;
    #1;
    total++; if (npc !== 32'h0000_3004) begin bad++; $display("FAIL fetch_npc got=%h exp=%h", npc, 32'h0000_3004); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL fetch_en got=%b exp=1", en); end
    step();
    total++; if (d_pc !== 32'h0000_3000) begin bad++; $display("FAIL fetch_dpc got=%h exp=%h", d_pc, 32'h0000_3000); end
    total++; if (d_instr !== 32'h2401_0001) begin bad++; $display("FAIL fetch_dinstr got=%h exp=%h", d_instr, 32'h2401_0001); end
    total++; if (d_valid !== 1'b1) begin bad++; $display("FAIL fetch_dvalid got=%b exp=1", d_valid); end
    total++; if (fetch_cnt !== 32'd1) begin bad++; $display("FAIL fetch_cnt got=%0d exp=1", fetch_cnt); end
  endtask

  task automatic test_stall();
    stall = 1'b1; pc = 32'h0000_3008; instr = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (en !== 1'b0) begin bad++; $display("FAIL stall_en cyc=%0d got=%b exp=0", i, en); end
      step();
    end
    total++; if (d_pc !== 32'h0000_3000 || d_instr !== 32'h2401_0001) begin bad++; $display("FAIL stall_hold got=%h/%h exp=%h/%h", d_pc, d_instr, 32'h0000_3000, 32'h2401_0001); end
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    total++; if (fetch_cnt !== 32'd1) begin bad++; $display("FAIL stall_fcnt got=%0d exp=1", fetch_cnt); end
  endtask

  task automatic test_branch();
    stall = 1'b0; pc = 32'h0000_3010; instr = 32'h3333_4444;
    br_valid = 1'b1; br_target = 32'h0000_3040;
    #1;
    total++; if (npc !== 32'h0000_3040) begin bad++; $display("FAIL br_npc got=%h exp=%h", npc, 32'h0000_3040); end
    step();
    br_valid = 1'b0;
    total++; if (d_pc !== 32'h0000_3010 || d_instr !== 32'h3333_4444) begin bad++; $display("FAIL br_delayslot got=%h/%h exp=%h/%h", d_pc, d_instr, 32'h0000_3010, 32'h3333_4444); end
    total++; if (fetch_cnt !== 32'd2) begin bad++; $display("FAIL br_fcnt got=%0d exp=2", fetch_cnt); end
    pc = 32'h0000_3040;
    #1;
    total++; if (npc !== 32'h0000_3044) begin bad++; $display("FAIL br_nopend got=%h exp=%h", npc, 32'h0000_3044); end
  endtask

  task automatic test_stalled_branch();
    pc = 32'h0000_3044; instr = 32'h5555_6666;
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
    step();
    br_valid = 1'b0; br_target = 32'h0;
    #1;
    total++; if (npc !== 32'h0000_3100) begin bad++; $display("FAIL sbr_pend got=%h exp=%h", npc, 32'h0000_3100); end
    step(); step();
    stall = 1'b0;
    #1;
    total++; if (npc !== 32'h0000_3100) begin bad++; $display("FAIL sbr_unstall got=%h exp=%h", npc, 32'h0000_3100); end
    total++; if (stall_cnt !== 32'd6) begin bad++; $display("FAIL sbr_scnt got=%0d exp=6", stall_cnt); end
    step();
    total++; if (npc !== 32'h0000_3048) begin bad++; $display("FAIL sbr_after got=%h exp=%h", npc, 32'h0000_3048); end
    total++; if (d_pc !== 32'h0000_3044 || fetch_cnt !== 32'd3) begin bad++; $display("FAIL sbr_latch got=%h/%0d exp=%h/3", d_pc, fetch_cnt, 32'h0000_3044); end
  endtask

  task automatic test_back_to_back();
    pc = 32'h0000_3100; instr = 32'h7777_8888; stall = 1'b1;
    br_valid = 1'b1; br_target = 32'h0000_3200;
    step();
    br_target = 32'h0000_3300;
    step();
    br_valid = 1'b0; br_target = 32'h0; stall = 1'b0;
    #1;
    total++; if (npc !== 32'h0000_3300) begin bad++; $display("FAIL b2b_npc got=%h exp=%h", npc, 32'h0000_3300); end
    step();
    total++; if (stall_cnt !== 32'd8 || fetch_cnt !== 32'd4) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=8/4", stall_cnt, fetch_cnt); end
  endtask

  task automatic test_boundaries();
    stall = 1'b0; pc = 32'hFFFF_FFFC;
    #1;
    total++; if (npc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_npc got=%h exp=%h", npc, 32'h0); end
    pc = 32'h0000_3020; br_valid = 1'b1; br_target = 32'h0000_3043;
    #1;
    total++; if (npc !== 32'h0000_3043) begin bad++; $display("FAIL unaligned_npc got=%h exp=%h", npc, 32'h0000_3043); end
    br_valid = 1'b0;
    step();
    total++; if (fetch_cnt !== 32'd5) begin bad++; $display("FAIL bnd_fcnt got=%0d exp=5", fetch_cnt); end
  endtask

  task automatic test_reset_pending();
    pc = 32'h0000_3050; stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
    step();
    br_valid = 1'b0; reset = 1'b1;
    #1;
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rstp_en got=%b exp=0", en); end
    step();
    reset = 1'b0;
    total++; if (d_valid !== 1'b0 || d_pc !== 32'h0000_3000) begin bad++; $display("FAIL rstp_d got=%b/%h exp=0/%h", d_valid, d_pc, 32'h0000_3000); end
    total++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL rstp_cnt got=%0d/%0d exp=0/0", fetch_cnt, stall_cnt); end
    stall = 1'b0; pc = 32'h0000_3000;
    #1;
    total++; if (npc !== 32'h0000_3004) begin bad++; $display("FAIL rstp_npc got=%h exp=%h", npc, 32'h0000_3004); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_stalled_branch();
    test_back_to_back();
    test_boundaries();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC and fetch-side pipeline controller, sitting directly downstream of the instruction fetch unit. It consumes the fetched PC/instruction pair and latches it into the IF/ID pipeline register. It generates the next-PC value and the PC write-enable back to the fetch unit, applying stalls from the hazard unit and branch/jump redirects from the decode stage under MIPS delay-slot semantics. It also keeps fetched-instruction and stall-cycle counters for debug.

## Interface
Parameters:
- RESET_PC, 32'h3000, PC value presented in the IF/ID register after reset (matches fetch unit reset PC)

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- FC_i_PC  in  32  current PC from fetch unit
- FC_i_Instr  in  32  instruction fetched at FC_i_PC
- FC_i_Stall  in  1  hazard-unit stall request; freezes PC and IF/ID register
- FC_i_BrValid  in  1  one-cycle pulse from decode: taken branch/jump resolved
- FC_i_BrTarget  in  32  redirect target, valid with FC_i_BrValid
- FC_o_nPC  out  32  next PC to fetch unit
- FC_o_En  out  1  PC write-enable to fetch unit
- FC_o_D_Instr  out  32  IF/ID instruction
- FC_o_D_PC  out  32  IF/ID PC
- FC_o_D_Valid  out  1  IF/ID holds a real fetched instruction
- FC_o_FetchCnt  out  32  count of instructions accepted into IF/ID
- FC_o_StallCnt  out  32  count of stalled cycles

## Operation
- FC_o_En = !FC_i_Stall (combinational).
- Redirect source: if FC_i_BrValid, use FC_i_BrTarget; else if pending flag set, use pending target; else no redirect.
- FC_o_nPC = redirect target when a redirect is selected, else FC_i_PC + 4 (32-bit, wraps modulo 2^32).
- Pending redirect register (flag + 32-bit target):
  - FC_i_BrValid && FC_i_Stall: latch FC_i_BrTarget, flag=1. A new pulse overwrites an older pending target.
  - !FC_i_Stall: flag cleared (the redirect is consumed this cycle, either fresh or pending).
  - A fresh FC_i_BrValid takes precedence over the pending target.
- Delay slot: the redirect affects only the PC after the current FC_i_PC. The instruction currently in fetch (the delay slot) is always latched into IF/ID, never squashed.
- IF/ID register:
  - !FC_i_Stall: load FC_i_Instr, FC_i_PC, Valid=1.
  - FC_i_Stall: hold all three.
- Counters:
  - FetchCnt += 1 on every non-stalled, non-reset cycle.
  - StallCnt += 1 on every stalled, non-reset cycle.
  - Both wrap at 2^32.
- No alignment checking on the target; low two bits are passed through unchanged.

## Timing
- Reset (sampled at posedge, overrides all inputs):
  - D_Instr=0, D_PC=RESET_PC, D_Valid=0.
  - Pending flag=0, pending target=0.
  - FetchCnt=0, StallCnt=0.
  - FC_o_En and FC_o_nPC remain combinational during reset. The fetch unit's own reset dominates.
- nPC/En: zero-cycle (combinational) from FC_i_PC, FC_i_Stall, FC_i_BrValid and the pending register.
- IF/ID: 1-cycle latency; the fetch pair visible at edge N appears on D outputs after edge N.
- Stall for k cycles: PC and IF/ID frozen for k edges. StallCnt += k; FetchCnt unchanged.
- Redirect during stall: applied on the first unstalled cycle; nPC = latched target on that cycle.
- Redirect pulse on an unstalled cycle: nPC = target in that same cycle; no pending state created.
- Reset asserted with a pending redirect: pending is discarded. The first post-reset nPC is FC_i_PC + 4.

## Structure
- Shared package/header: RESET_PC default (32'h3000) and the PC increment constant 4, shared with the fetch unit.
- One natural sub-module: `pending_redirect`, holding the flag and target register plus the select mux.
- Top level holds the IF/ID register and the counters.

## Test plan
- Reset, then stall=0 with PC=0x3000, Instr=0x24010001 -> nPC=0x3004, En=1. After the edge: D_PC=0x3000, D_Instr=0x24010001, D_Valid=1, FetchCnt=1.
- Stall=1 for 3 cycles at PC=0x3008 -> En=0 throughout, D outputs unchanged, StallCnt=3, FetchCnt unchanged.
- BrValid pulse, target=0x3040, stall=0, PC=0x3010 -> nPC=0x3040 that cycle. Instr at 0x3010 (delay slot) is latched into IF/ID.
- BrValid pulse target=0x3100 with stall=1, then 2 more stall cycles, then stall=0 -> nPC=0x3100 on the unstall cycle, PC+4 on the cycle after.
- Two pulses during one stall (0x3200, then 0x3300) -> unstall nPC=0x3300.
- Reset asserted while pending=0x3100 and stall=1 -> after the edge: D_Valid=0, D_PC=0x3000, both counters 0. With stall=0 and PC=0x3000, nPC=0x3004.
